// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU front end: walks one external 1-bit ALU slice across a
// WIDTH-bit operation LSB-first, threading carry and resolving set-less-than
// with an extra pass over bit 0.
module alu_serial_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       op_in,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_less,
  output logic [2:0]       slice_op,
  input  logic             slice_result,
  input  logic             slice_cout,
  input  logic             slice_set,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [2:0] OP_LESS = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             carry_q;
  logic             set_msb;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] result_next;
  logic             last_bit;

  assign last_bit = (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; the extra FIX pass only exists for the signed LESS op
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last_bit) state_next = (op_q == OP_LESS) ? FIX : DONE;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: slice drives come only from latched operands and idx
  always_comb begin
    ready      = (state == IDLE);
    done       = (state == DONE);
    slice_a    = 1'b0;
    slice_b    = 1'b0;
    slice_cin  = 1'b0;
    slice_less = 1'b0;
    slice_op   = 3'b000;
    case (state)
      RUN: begin
        slice_a   = a_q[idx];
        slice_b   = b_q[idx];
        slice_cin = carry_q;
        slice_op  = op_q;
      end
      FIX: begin
        slice_a    = a_q[0];
        slice_b    = b_q[0];
        slice_cin  = op_q[2];
        slice_less = set_msb;
        slice_op   = op_q;
      end
      default: ;
    endcase
  end

  // Result vector with the bit currently being produced by the slice merged in
  always_comb begin
    result_next = result;
    if (state == FIX) result_next[0]   = slice_result;
    else              result_next[idx] = slice_result;
  end

  // Datapath: latch on accept, capture one bit per RUN edge, patch bit 0 in FIX
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      carry_q   <= 1'b0;
      set_msb   <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q       <= a_in;
          b_q       <= b_in;
          op_q      <= op_in;
          carry_q   <= op_in[2];
          set_msb   <= 1'b0;
          idx       <= '0;
          result    <= '0;
          carry_out <= 1'b0;
          overflow  <= 1'b0;
          zero      <= 1'b0;
        end
        RUN: begin
          result  <= result_next;
          carry_q <= slice_cout;
          if (last_bit) begin
            carry_out <= slice_cout;
            overflow  <= carry_q ^ slice_cout;
            set_msb   <= slice_set;
            zero      <= (result_next == '0);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        FIX: begin
          result <= result_next;
          zero   <= (result_next == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Scoreboard bench for alu_serial_sequencer with a behavioural 1-bit slice.
module tb_alu_serial_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       ready;
  logic [7:0] a_in, b_in;
  logic [2:0] op_in;
  logic       slice_a, slice_b, slice_cin, slice_less;
  logic [2:0] slice_op;
  logic       slice_result, slice_cout, slice_set;
  logic [7:0] result;
  logic       carry_out, overflow, zero, done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] res;
    logic       co;
    logic       ov;
    logic       z;
    int         lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Behavioural 1-bit ALU slice
  logic bb_s, sum_s;
  assign bb_s       = slice_b ^ slice_op[2];
  assign sum_s      = slice_a ^ bb_s ^ slice_cin;
  assign slice_set  = sum_s;
  assign slice_cout = (slice_a & bb_s) | (slice_a & slice_cin) | (bb_s & slice_cin);
  always_comb begin
    case (slice_op[1:0])
      2'b00:   slice_result = slice_a & bb_s;
      2'b01:   slice_result = slice_a | bb_s;
      2'b10:   slice_result = sum_s;
      default: slice_result = slice_less;
    endcase
  end

  alu_serial_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_less(slice_less), .slice_op(slice_op),
    .slice_result(slice_result), .slice_cout(slice_cout), .slice_set(slice_set),
    .result(result), .carry_out(carry_out), .overflow(overflow),
    .zero(zero), .done(done)
  );

  // Word-level reference: whole-operand arithmetic, not a bit walk
  function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    exp_t e;
    logic [7:0] bb;
    logic [8:0] s;
    bb = op[2] ? ~b : b;
    s = {1'b0, a} + {1'b0, bb} + {8'b0, op[2]};
    e.co = s[8];
    e.ov = s[7] ^ a[7] ^ bb[7] ^ s[8];
    case (op[1:0])
      2'b00:   e.res = a & bb;
      2'b01:   e.res = a | bb;
      2'b10:   e.res = s[7:0];
      default: e.res = (op == 3'b111) ? {7'b0, s[7]} : 8'h00;
    endcase
    e.z = (e.res == 8'h00);
    e.lat = (op == 3'b111) ? 10 : 9;
    return e;
  endfunction

  // Drive one operation and collect outputs in the done cycle
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        output logic [10:0] obs, output int lat, output time stamp);
    int guard;
    guard = 0;
    @(negedge clk);
    while (ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a_in = a; b_in = b; op_in = op; start = 1'b1;
    @(posedge clk);
    stamp = $time;
    #1 start = 1'b0;
    lat = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) break;
      @(posedge clk);
      lat++;
    end
    obs = {result, carry_out, overflow, zero};
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a_in = 8'h00; b_in = 8'h00; op_in = 3'b000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if ({ready, done} !== 2'b10) begin
      bad++; $display("[TB] FAIL reset_hs got ready/done=%b want 10", {ready, done});
    end
    total++;
    if ({result, carry_out, overflow, zero} !== 11'h000) begin
      bad++; $display("[TB] FAIL reset_out got %h want 000", {result, carry_out, overflow, zero});
    end
    total++;
    if ({slice_a, slice_b, slice_cin, slice_less, slice_op} !== 7'h00) begin
      bad++; $display("[TB] FAIL reset_slice got %h want 00",
                      {slice_a, slice_b, slice_cin, slice_less, slice_op});
    end
  endtask

  task automatic test_ops();
    logic [7:0]  ta[6] = '{8'h7F, 8'h05, 8'h03, 8'h05, 8'hF0, 8'hA0};
    logic [7:0]  tb[6] = '{8'h01, 8'h05, 8'h05, 8'h03, 8'h30, 8'h05};
    logic [2:0]  to[6] = '{3'b010, 3'b110, 3'b111, 3'b111, 3'b100, 3'b001};
    logic [10:0] obs;
    int lat;
    time st;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(model(ta[i], tb[i], to[i]));
      run_op(ta[i], tb[i], to[i], obs, lat, st);
      e = sb.pop_front();
      total++;
      if (obs !== {e.res, e.co, e.ov, e.z}) begin
        bad++; $display("[TB] FAIL op%0d res/co/ov/z got %h want %h", i, obs, {e.res, e.co, e.ov, e.z});
      end
      total++;
      if (lat != e.lat) begin
        bad++; $display("[TB] FAIL op%0d latency got %0d want %0d", i, lat, e.lat);
      end
    end
  endtask

  task automatic test_start_held();
    exp_t e;
    int lat;
    sb.push_back(model(8'h12, 8'h34, 3'b010));
    @(negedge clk);
    a_in = 8'h12; b_in = 8'h34; op_in = 3'b010; start = 1'b1;
    @(posedge clk);
    #1 a_in = 8'hFF; b_in = 8'hFF; op_in = 3'b111;
    lat = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) break;
      @(posedge clk);
      lat++;
    end
    start = 1'b0;
    e = sb.pop_front();
    total++;
    if ({result, carry_out, overflow, zero} !== {e.res, e.co, e.ov, e.z}) begin
      bad++; $display("[TB] FAIL held_start got %h want %h",
                      {result, carry_out, overflow, zero}, {e.res, e.co, e.ov, e.z});
    end
    total++;
    if (lat != e.lat) begin
      bad++; $display("[TB] FAIL held_latency got %0d want %0d", lat, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] obs1, obs2;
    int lat1, lat2;
    time st1, st2;
    exp_t e;
    sb.push_back(model(8'h10, 8'h20, 3'b010));
    run_op(8'h10, 8'h20, 3'b010, obs1, lat1, st1);
    sb.push_back(model(8'h40, 8'h01, 3'b110));
    run_op(8'h40, 8'h01, 3'b110, obs2, lat2, st2);
    e = sb.pop_front();
    total++;
    if (obs1 !== {e.res, e.co, e.ov, e.z}) begin
      bad++; $display("[TB] FAIL b2b_first got %h want %h", obs1, {e.res, e.co, e.ov, e.z});
    end
    e = sb.pop_front();
    total++;
    if (obs2 !== {e.res, e.co, e.ov, e.z}) begin
      bad++; $display("[TB] FAIL b2b_second got %h want %h", obs2, {e.res, e.co, e.ov, e.z});
    end
    total++;
    if ((st2 - st1) / 10 != 10) begin
      bad++; $display("[TB] FAIL b2b_interval got %0d want 10", (st2 - st1) / 10);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [10:0] obs;
    int lat;
    time st;
    exp_t e;
    @(negedge clk);
    a_in = 8'hFF; b_in = 8'h01; op_in = 3'b010; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if ({ready, done, result} !== {2'b10, 8'h00}) begin
      bad++; $display("[TB] FAIL midrun_reset got ready/done/result=%h want 200", {ready, done, result});
    end
    sb.push_back(model(8'h01, 8'h02, 3'b010));
    run_op(8'h01, 8'h02, 3'b010, obs, lat, st);
    e = sb.pop_front();
    total++;
    if (obs !== {e.res, e.co, e.ov, e.z}) begin
      bad++; $display("[TB] FAIL post_reset_add got %h want %h", obs, {e.res, e.co, e.ov, e.z});
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("[TB] FAIL scoreboard_left got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_serial_sequencer.md
# alu_serial_sequencer

Bit-serial ALU sequencer that computes a WIDTH-bit operation one bit per clock through a single external 1-bit ALU slice. It latches operands and opcode on a start handshake, drives the slice LSB-first, and threads the slice carry-out back into carry-in. For set-less-than it feeds the MSB `set` back through the slice `less` input. It is the initiating side of the 1-bit slice interface (a, b, cin, less, op -> result, cout, set) and is the multi-cycle ALU front end for cores that instantiate only one slice.

## Interface
- WIDTH, 8, operand/result width in bits (>= 2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start  input  1  request; accepted only when ready=1
- ready  output  1  high in IDLE only
- a_in  input  WIDTH  operand A, sampled with start
- b_in  input  WIDTH  operand B, sampled with start
- op_in  input  3  opcode, sampled with start: bit2 = b-invert and initial carry; bits1:0 = 00 AND, 01 OR, 10 ADD, 11 LESS
- slice_a, slice_b, slice_cin, slice_less  output  1 each  drive to slice
- slice_op  output  3  drive to slice, equals latched opcode
- slice_result, slice_cout, slice_set  input  1 each  from slice (slice g/p unused)
- result  output  WIDTH  final result, held until next accepted start
- carry_out  output  1  slice_cout captured at MSB
- overflow  output  1  carry into MSB XOR carry out of MSB
- zero  output  1  result == 0
- done  output  1  one-cycle pulse, outputs valid

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: ready=1. On start=1, latch a_in, b_in, op_in; set carry register to op_in[2]; set bit index to 0; clear result; go to RUN.
- RUN: drive the slice with the following values.
  - slice_a = A[idx], slice_b = B[idx].
  - slice_cin = carry register, slice_less = 0, slice_op = latched op.
- On each RUN edge, perform these captures.
  - Capture result[idx] = slice_result and carry register = slice_cout.
  - At idx = WIDTH-1, also capture carry_out = slice_cout, overflow = slice_cin ^ slice_cout, and set_msb = slice_set.
  - Then go to FIX if op = 111, else go to DONE. Otherwise increment idx.
- FIX (LESS op only): drive bit 0 again with slice_cin = op[2] and slice_less = set_msb. On the edge, capture result[0] = slice_result and go to DONE.
  - LESS therefore yields result = {0…0, set_msb}, where set_msb is the raw MSB sum with no overflow correction.
- DONE: done=1 and zero = (result == 0). Next edge goes to IDLE.
- Outside RUN and FIX, all slice_* outputs are driven 0.
- Logic ops still propagate the carry. carry_out and overflow are reported for every op.
- start in RUN, FIX or DONE is ignored. No queueing.

## Timing
- Reset (synchronous) values:
  - state IDLE, ready=1, done=0.
  - result=0, carry_out=0, overflow=0, zero=0.
  - idx=0, slice_* = 0.
- Reset asserted in any state aborts the operation and produces the reset values on the following cycle.
- Start accepted at edge E0:
  - Bit i is captured at edge E(i+1).
  - Non-LESS ops: done high in the cycle following E(WIDTH), i.e. WIDTH+1 cycles after acceptance.
  - LESS: FIX adds one cycle, so done is high after E(WIDTH+1).
- ready returns high the cycle after done. A start in that cycle is accepted, giving a minimum issue interval of WIDTH+2 cycles (WIDTH+3 for LESS).
- Slice is purely combinational. The sequencer's slice drives come from registers and idx, with no combinational input-to-output path other than through the slice.
- result, carry_out, overflow and zero are registered. They remain stable from the done cycle until the next accepted start clears them.

## Test plan
- ADD (010), WIDTH=8, a=0x7F, b=0x01 -> result 0x80, carry_out 0, overflow 1, zero 0; done exactly 9 cycles after the start edge.
- SUB (110), a=0x05, b=0x05 -> result 0x00, zero 1, carry_out 1, overflow 0.
- LESS (111) cases:
  - a=0x03, b=0x05 -> result 0x01.
  - a=0x05, b=0x03 -> result 0x00.
  - done in both cases is 10 cycles after the start edge.
- AND with b-invert (100), a=0xF0, b=0x30 -> result 0xC0. OR (001), a=0xA0, b=0x05 -> result 0xA5.
- Handshake:
  - start held high during RUN is ignored and the first result is unchanged.
  - A new start in the cycle after done is accepted, and its result is correct.
- Reset pulse while idx=3 in RUN -> next cycle ready=1, done=0, result=0. A following ADD 0x01+0x02 gives 0x03.
